// File: rtl/cdt_pkg.sv
// Shared constants, FSM state type, cosine ROM and pass scaling for the 8x8 cosine transforms.
// Define CDT_ROUND_EN to round half up before each pass shift; otherwise the shift floors.
package cdt_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int COEF_W    = 13;
  localparam int OUT_W     = 22;
  localparam int FRAC      = 8;
  localparam int P1_SUM_W  = 32;
  localparam int P2_SUM_W  = 38;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1     = 3'd1,
    DRAIN  = 3'd2,
    P2     = 3'd3,
    P2_END = 3'd4,
    DONE   = 3'd5
  } cdt_state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // C[u][k] = round(256 * a(u) * cos((2k+1)u*pi/16)); rows 1..7 sum to zero.
  localparam coef_t CDT_ROM [8][8] = '{
    '{ 13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91 },
    '{ 13'sd126,  13'sd106,  13'sd71,   13'sd25,  -13'sd25,  -13'sd71,  -13'sd106, -13'sd126 },
    '{ 13'sd118,  13'sd49,  -13'sd49,  -13'sd118, -13'sd118, -13'sd49,   13'sd49,   13'sd118 },
    '{ 13'sd106, -13'sd25,  -13'sd126, -13'sd71,   13'sd71,   13'sd126,  13'sd25,  -13'sd106 },
    '{ 13'sd91,  -13'sd91,  -13'sd91,   13'sd91,   13'sd91,  -13'sd91,  -13'sd91,   13'sd91 },
    '{ 13'sd71,  -13'sd126,  13'sd25,   13'sd106, -13'sd106, -13'sd25,   13'sd126, -13'sd71 },
    '{ 13'sd49,  -13'sd118,  13'sd118, -13'sd49,  -13'sd49,   13'sd118, -13'sd118,  13'sd49 },
    '{ 13'sd25,  -13'sd71,   13'sd106, -13'sd126,  13'sd126, -13'sd106,  13'sd71,  -13'sd25 }
  };

  localparam logic signed [P2_SUM_W-1:0] ROUND_K = P2_SUM_W'(2 ** (FRAC - 1));

  // Both passes share this; a pass-1 sum is sign-extended to the wider width first.
  function automatic logic [OUT_W-1:0] cdt_scale(input logic signed [P2_SUM_W-1:0] sum);
`ifdef CDT_ROUND_EN
    return OUT_W'((sum + ROUND_K) >>> FRAC);
`else
    return OUT_W'(sum >>> FRAC);
`endif
  endfunction

endpackage

// File: rtl/cdt_tbuf.sv
// 8x8 transpose buffer: single (i,j) write port, registered full-column read port.
module cdt_tbuf
  import cdt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [2:0]         wr_i_i,
  input  logic [2:0]         wr_j_i,
  input  logic [OUT_W-1:0]   wr_data_i,
  input  logic               rd_en_i,
  input  logic [2:0]         rd_col_i,
  output logic [8*OUT_W-1:0] rd_data_o
);

  logic [OUT_W-1:0]   mem_q [8][8];
  logic [8*OUT_W-1:0] rd_q;

  // Storage is deliberately left without reset; every pass 1 rewrites all 64 entries.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_i_i][wr_j_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      for (int k = 0; k < 8; k++) rd_q[k*OUT_W +: OUT_W] <= mem_q[k][rd_col_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/fcdt.sv
// Forward 8x8 cosine transform: row pass into a transpose buffer, column pass to a valid/ready stream.
// Define CDT_ROUND_EN to round half up before each pass shift (default: floor).
module fcdt
  import cdt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [2:0]            mem_row,
  input  logic [8*SAMPLE_W-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_i,
  output logic [2:0]            out_j,
  output logic [OUT_W-1:0]      out_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state_o
);

  // Output handshake: a coefficient transfers on a clock edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_i/out_j/out_data are held unchanged.

  cdt_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       p1_vld_q;
  logic [5:0] p1_idx_q;
  logic       out_valid_q, out_valid_d;
  logic [5:0] out_idx_q, out_idx_d;
  logic       stall;
  logic       p2_issue;

  logic [8*OUT_W-1:0]          col_data;
  logic signed [P1_SUM_W-1:0]  p1_sum;
  logic signed [P2_SUM_W-1:0]  p2_sum;
  logic [OUT_W-1:0]            p1_result;

  assign stall    = out_valid_q && !out_ready;
  assign p2_issue = (state_q == P2) && !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = P1;
          cnt_d   = '0;
        end
      end
      P1: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = DRAIN;
      end
      DRAIN: state_d = P2;
      P2: begin
        if (!stall) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = P2_END;
        end
      end
      P2_END: begin
        if (out_valid_q && out_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (p2_issue) begin
      out_valid_d = 1'b1;
      out_idx_d   = cnt_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p1_vld_q    <= 1'b0;
      p1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_vld_q    <= (state_q == P1);
      p1_idx_q    <= cnt_q;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Row pass: memory row arrives one cycle after the strobe; ROM row is the column index j.
  always_comb begin
    p1_sum = '0;
    for (int k = 0; k < 8; k++) begin
      p1_sum = p1_sum
             + P1_SUM_W'($signed(mem_data[k*SAMPLE_W +: SAMPLE_W]))
             * P1_SUM_W'(CDT_ROM[p1_idx_q[2:0]][k]);
    end
  end

  assign p1_result = cdt_scale(P2_SUM_W'(p1_sum));

  cdt_tbuf u_tbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (p1_vld_q),
    .wr_i_i    (p1_idx_q[5:3]),
    .wr_j_i    (p1_idx_q[2:0]),
    .wr_data_i (p1_result),
    .rd_en_i   (p2_issue),
    .rd_col_i  (cnt_q[2:0]),
    .rd_data_o (col_data)
  );

  // Column pass: buffer column j against ROM row i, both held by the output registers.
  always_comb begin
    p2_sum = '0;
    for (int k = 0; k < 8; k++) begin
      p2_sum = p2_sum
             + P2_SUM_W'(CDT_ROM[out_idx_q[5:3]][k])
             * P2_SUM_W'($signed(col_data[k*OUT_W +: OUT_W]));
    end
  end

  assign out_data    = out_valid_q ? cdt_scale(p2_sum) : '0;
  assign out_valid   = out_valid_q;
  assign out_i       = out_idx_q[5:3];
  assign out_j       = out_idx_q[2:0];
  assign mem_rd_en   = (state_q == P1);
  assign mem_row     = mem_rd_en ? cnt_q[5:3] : 3'd0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fcdt.sv
// Directed bench for fcdt: block stimulus, scoreboard queue with a decoupled output monitor.
module tb_fcdt;

  localparam int K_ZERO = 0;
  localparam int K_POS  = 1;
  localparam int K_NEG  = 2;
  localparam int K_IMP  = 3;

`ifdef CDT_ROUND_EN
  localparam int Y00_POS = 808;
  localparam int Y00_NEG = -808;
  localparam int RND     = 128;
`else
  localparam int Y00_POS = 807;
  localparam int Y00_NEG = -811;
  localparam int RND     = 0;
`endif

  // ROM column 0, written out by hand for the impulse response.
  localparam int C0 [8] = '{91, 126, 118, 106, 91, 71, 49, 25};

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mem_rd_en;
  logic [2:0]   mem_row;
  logic [127:0] mem_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_i;
  logic [2:0]   out_j;
  logic [21:0]  out_data;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  fcdt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mem_rd_en   (mem_rd_en),
    .mem_row     (mem_row),
    .mem_data    (mem_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_i       (out_i),
    .out_j       (out_j),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  always @(posedge clk) edge_cnt++;

  function automatic int rel();
    return edge_cnt - start_edge + 1;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, rel());
    end
  endtask

  // ---------------- block memory model ----------------
  logic [127:0] blk_mem [8];

  initial mem_data = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= blk_mem[mem_row];
  end

  task automatic load_block(input int kind);
    int s;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        case (kind)
          K_POS:   s = 100;
          K_NEG:   s = -100;
          K_IMP:   s = (r == 0 && k == 0) ? 256 : 0;
          default: s = 0;
        endcase
        blk_mem[r][k*16 +: 16] = 16'(s);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [27:0] exp_q [$];
  logic [27:0] held;
  logic [27:0] cur;
  logic [27:0] exp_e;
  logic        hold_vld = 1'b0;
  int          first_vld_cyc = -1;
  int          rd_cnt = 0;
  int          last_rd_cyc = -1;

  task automatic push_expected(input int kind);
    int v;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        v = 0;
        case (kind)
          K_POS:   if (i == 0 && j == 0) v = Y00_POS;
          K_NEG:   if (i == 0 && j == 0) v = Y00_NEG;
          K_IMP:   v = (C0[i] * C0[j] + RND) >>> 8;
          default: v = 0;
        endcase
        exp_q.push_back({3'(i), 3'(j), 22'(v)});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt++;
        last_rd_cyc = rel();
      end
      if (out_valid) begin
        cur = {out_i, out_j, out_data};
        if (first_vld_cyc < 0) first_vld_cyc = rel();
        if (hold_vld) check("held_output", cur, held);
        if (out_ready) begin
          check("output_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("coef_ij", {out_i, out_j}, exp_e[27:22]);
            check("coef_data", $signed(out_data), $signed(exp_e[21:0]));
          end
          hold_vld = 1'b0;
        end else begin
          hold_vld = 1'b1;
          held     = cur;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_edge = edge_cnt;
    check("busy_after_start", busy, 1);
    check("rd_en_cycle1", mem_rd_en, 1);
  endtask

  task automatic run_block(input int kind, input int stall_len, input int exp_done);
    int done_cyc;
    done_cyc      = -1;
    load_block(kind);
    push_expected(kind);
    first_vld_cyc = -1;
    rd_cnt        = 0;
    last_rd_cyc   = -1;
    do_start();
    fork
      begin
        if (stall_len > 0) begin
          repeat (75) @(posedge clk);
          #1 out_ready = 1'b0;
          repeat (stall_len) @(posedge clk);
          #1 out_ready = 1'b1;
        end
      end
      begin
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (done) begin
            done_cyc = rel();
            break;
          end
        end
      end
    join
    check("done_seen", done, 1);
    check("done_cycle", done_cyc, exp_done);
    check("busy_at_done", busy, 1);
    check("first_valid_cycle", first_vld_cyc, 67);
    check("rd_count", rd_cnt, 64);
    check("last_rd_cycle", last_rd_cyc, 64);
    check("queue_drained", exp_q.size(), 0);
    // start coinciding with DONE must not launch a new block
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_in_done_busy", busy, 0);
    check("start_in_done_state", dbg_state, 0);
    check("done_pulse_width", done, 0);
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_rd_en"},     mem_rd_en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_ij"},    {out_i, out_j}, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_state"},     dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_outputs_check("reset");
    rst_n = 1'b1;

    run_block(K_ZERO, 0, 131);
    run_block(K_POS,  0, 131);
    run_block(K_NEG,  0, 131);
    run_block(K_IMP,  0, 131);
    run_block(K_POS,  5, 136);

    // start during P2 is ignored, then an asynchronous reset aborts the block
    load_block(K_POS);
    push_expected(K_POS);
    do_start();
    repeat (79) @(posedge clk);
    #1 check("in_p2_state", dbg_state, 3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_in_p2_state", dbg_state, 3);
    check("start_in_p2_busy", busy, 1);
    repeat (5) @(posedge clk);
    #1 check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1 reset_outputs_check("mid_p2_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_block(K_POS, 0, 131);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fcdt.md
# fcdt

Forward 8×8 two-dimensional cosine transform engine; the encoder-side counterpart of the inverse-transform block. Reads an 8×8 block of signed samples row by row from block memory. Computes Y = C·X·Cᵀ in two separable passes through an internal 8×8 transpose buffer. Streams the 64 coefficients out in row-major order over a valid/ready interface.

## Interface
- SAMPLE_W, 16, signed input sample width (8 samples packed per memory row)
- COEF_W, 13, signed cosine-ROM entry width
- OUT_W, 22, signed width of transpose-buffer entries and output coefficients
- FRAC, 8, fractional bits of ROM entries; the shift applied after each pass
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to transform one block; ignored unless idle
- mem_rd_en  out  1  row read strobe
- mem_row  out  3  row address presented with mem_rd_en
- mem_data  in  128  row data, valid the cycle after mem_rd_en; sample k at [16k+15:16k]
- out_valid  out  1  out_data/out_i/out_j valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_i, out_j  out  3 each  coefficient row, column
- out_data  out  22  signed coefficient Y[out_i][out_j]
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last coefficient is accepted

## Operation
- ROM: C[u][k] = round(256·a(u)·cos((2k+1)uπ/16)), with a(0)=√(1/8) and a(u≥1)=1/2. Row 0 is all 91. Rows 1–7 each sum to exactly 0.
- FSM states:
  - IDLE → P1 on start.
  - P1: 64 cycles, then → DRAIN.
  - DRAIN: 1 cycle, then → P2.
  - P2: 64 issue cycles, then → P2_END.
  - P2_END: waits for the last acceptance, then → DONE.
  - DONE: 1 cycle with done=1, then → IDLE.
- P1: counters i (outer) and j (inner) issue one element per cycle.
  - mem_rd_en=1 and mem_row=i each cycle.
  - The next cycle computes T[i][j] = (Σk X[i][k]·C[j][k]) >>> FRAC and writes it to buffer (i,j).
- P2: same issue order.
  - Reads buffer column j and ROM row i.
  - Next cycle: out_data = (Σk C[i][k]·T[k][j]) >>> FRAC.
- Arithmetic widths:
  - P1 products are 29 bits, sum is 32 bits. After the shift, bits [21:0] are kept.
  - P2 products are 35 bits, sum is 38 bits. After the shift, bits [21:0] are kept.
  - No overflow is reachable with this ROM and SAMPLE_W.
- Shift rounding is floor (arithmetic shift) unless configured otherwise.
- Backpressure: while out_valid && !out_ready, counters, ROM/buffer read registers and the output register hold. out_data, out_i and out_j stay stable.
- start while busy is ignored. start and DONE in the same cycle: start is ignored.
- Reset:
  - Outputs reset to 0 and the FSM to IDLE, asynchronously at any point, including mid-pass.
  - Transpose-buffer contents are not reset.

## Timing
- start sampled high at edge 0 gives:
  - P1 issues in cycles 1–64; mem_rd_en high in cycles 1–64.
  - Last buffer write at the end of cycle 65 (DRAIN).
  - P2 issues in cycles 66–129; out_valid high in cycles 67–130.
  - done high in cycle 131; busy high in cycles 1–131.
- Each cycle of out_ready low while out_valid is high delays the remaining outputs and done by one cycle.
- Latency from a P2 issue to its out_valid: 1 cycle. Latency from mem_rd_en to its buffer write: 1 cycle.

## Configuration
- CDT_ROUND_EN defined: 2^(FRAC−1) is added to each sum before the shift in both passes (round half up).
- CDT_ROUND_EN undefined: plain arithmetic shift (floor).

## Structure
- Package cdt_pkg holds:
  - the width constants;
  - the FSM state enum (IDLE, P1, DRAIN, P2, P2_END, DONE);
  - the 8×8 ROM constant array, shared with the inverse block.
- One sub-module, cdt_tbuf: an 8×8×OUT_W transpose buffer with a single (i,j) write port and a registered 8-entry column read port.

## Test plan
- All-zero block, out_ready=1 → 64 outputs of 0, out_valid in cycles 67–130, done in cycle 131.
- All samples +100, macro off → Y[0][0]=807, all other 63 coefficients 0. Same stimulus with CDT_ROUND_EN → Y[0][0]=808.
- All samples −100, macro off → Y[0][0]=−811, others 0; checks floor-shift sign handling.
- Impulse X[0][0]=256, others 0 → Y[i][j] = (C[i][0]·C[j][0]) >>> 8; Y[0][0]=32.
- DC +100 block with out_ready low for 5 cycles at the 10th coefficient → that coefficient held stable, no loss or duplication, done in cycle 136.
- start pulsed during P2 → ignored. Then rst_n low mid-P2 → all outputs 0 immediately. A new start then yields a correct full block with done in cycle 131 relative to the new start.
